rr_mux_arbiter_8: RTL



---
 rtl/rr_mux_arbiter_8_pkg.sv | 35 +++
 rtl/rr_mux_arbiter_8_mux.sv | 10 +
 rtl/rr_mux_arbiter_8.sv | 105 ++++++++++
 3 files changed

// File: rtl/rr_mux_arbiter_8_pkg.sv
// Shared types and helpers for the round-robin serial mux arbiter.
// Holds the FSM state encoding and the circular priority search used by the top.
package rr_mux_arbiter_8_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } pick_t;

    // Scans from the highest offset down so the offset closest to ptr wins last.
    function automatic pick_t rr_pick(input logic [N_REQ-1:0] req,
                                      input logic [SEL_W-1:0] ptr);
        pick_t            p;
        logic [SEL_W-1:0] k;
        p.found = 1'b0;
        p.idx   = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            k = ptr + SEL_W'(j);
            if (req[k]) begin
                p.found = 1'b1;
                p.idx   = k;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_8_mux.sv
// Structural 8:1 single-bit multiplexer cell shared by all requester lanes.
module mux_8x1 (
    input  logic [7:0] i,
    input  logic [2:0] sel,
    output logic       out
);

    assign out = i[sel];

endmodule

// File: rtl/rr_mux_arbiter_8.sv
// Round-robin arbiter sharing one 8:1 bit-serial mux between eight requesters.
// Each grant lasts at most BURST_LEN transfers and is followed by one arbitration cycle.
module rr_mux_arbiter_8
    import rr_mux_arbiter_8_pkg::*;
#(
    parameter int BURST_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] din,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy
);

    localparam int               CNT_W    = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

    state_t             state, state_next;
    logic [N_REQ-1:0]   gnt_next;
    logic [SEL_W-1:0]   sel_next;
    logic [SEL_W-1:0]   ptr, ptr_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic               dout_next;
    logic               dout_valid_next;
    logic               mux_out;
    logic               end_grant;
    pick_t              pick;

    mux_8x1 u_mux (
        .i   (din),
        .sel (sel),
        .out (mux_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            gnt        <= '0;
            sel        <= '0;
            ptr        <= '0;
            cnt        <= '0;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
        end else begin
            state      <= state_next;
            gnt        <= gnt_next;
            sel        <= sel_next;
            ptr        <= ptr_next;
            cnt        <= cnt_next;
            dout       <= dout_next;
            dout_valid <= dout_valid_next;
        end
    end

    // A dropped req on the grantee ends the grant without a transfer; dout keeps its last bit.
    always_comb begin
        state_next      = state;
        gnt_next        = gnt;
        sel_next        = sel;
        ptr_next        = ptr;
        cnt_next        = cnt;
        dout_next       = dout;
        dout_valid_next = 1'b0;
        end_grant       = 1'b0;
        pick            = rr_pick(req, ptr);

        case (state)
            IDLE: begin
                if (pick.found) begin
                    state_next         = GRANT;
                    gnt_next           = '0;
                    gnt_next[pick.idx] = 1'b1;
                    sel_next           = pick.idx;
                    cnt_next           = '0;
                end
            end
            GRANT: begin
                if (req[sel]) begin
                    dout_next       = mux_out;
                    dout_valid_next = 1'b1;
                    cnt_next        = cnt + 1'b1;
                    end_grant       = (cnt == LAST_CNT);
                end else begin
                    end_grant = 1'b1;
                end
                if (end_grant) begin
                    state_next = IDLE;
                    gnt_next   = '0;
                    ptr_next   = sel + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                gnt_next   = '0;
            end
        endcase
    end

    assign busy = (state == GRANT);

endmodule
